// File: rtl/keypad_scan_if.sv
// Key-event handshake between the keypad scanner and its consumer.
// The master side presents the FIFO head; the slave side accepts it.
interface keypad_scan_if;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scan sequencer: row drive, press/release debounce,
// key encoding and a small key-event FIFO with valid/ready output.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  SCAN      | walking rows, waiting for any low column
//  DEB_PRESS | row frozen, counting stable ticks of the captured column
//  HELD      | key accepted, counting released ticks before returning
module keypad_scan_ctrl #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 64,
  parameter int REPEAT_RATE    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    col_in,
  output logic [3:0]    row_select,
  output logic          key_held,
  output logic          overflow,
  keypad_scan_if.master kbus
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Parameter sanity checks; elaboration only, no hardware.
  if (CLK_DIV < 2)        begin : g_chk_div  $error("CLK_DIV must be >= 2"); end
  if (DEBOUNCE_TICKS < 1) begin : g_chk_db   $error("DEBOUNCE_TICKS must be >= 1"); end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
                          begin : g_chk_fifo $error("FIFO_DEPTH must be a power of 2, >= 2"); end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1)
                          begin : g_chk_rep  $error("REPEAT_DELAY/REPEAT_RATE must be >= 1"); end

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [1:0]        row_q, row_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        lo_col;
  logic [DB_W-1:0]   db_q, db_d;
  logic [DB_W-1:0]   rel_q, rel_d;
  logic              push;
  logic [7:0]        push_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0]  rep_q, rep_d;
`endif

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop, full, accept;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Scan tick divider: free-running, wraps CLK_DIV-1 -> 0.
  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Lowest-index low column wins when several are pressed.
  always_comb begin
    lo_col = 2'd3;
    if      (!col_in[0]) lo_col = 2'd0;
    else if (!col_in[1]) lo_col = 2'd1;
    else if (!col_in[2]) lo_col = 2'd2;
  end

  // Next-state and event generation; every decision is taken on tick.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    db_d    = db_q;
    rel_d   = rel_q;
    push    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (col_in != 4'hF) begin
            col_d = lo_col;
            db_d  = DB_W'(1);
            if (DEBOUNCE_TICKS == 1) begin
              push    = 1'b1;
              rel_d   = '0;
              state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_d   = REP_W'(REPEAT_DELAY);
`endif
            end else begin
              state_d = DEB_PRESS;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEB_PRESS: begin
          if (!col_in[col_q]) begin
            db_d = db_q + DB_W'(1);
            if (db_d == DB_W'(DEBOUNCE_TICKS)) begin
              push    = 1'b1;
              rel_d   = '0;
              state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_d   = REP_W'(REPEAT_DELAY);
`endif
            end
          end else begin
            state_d = SCAN;
            row_d   = row_q + 2'd1;
          end
        end
        HELD: begin
          if (col_in == 4'hF) begin
            rel_d = rel_q + DB_W'(1);
            if (rel_d == DB_W'(DEBOUNCE_TICKS)) begin
              state_d = SCAN;
              row_d   = row_q + 2'd1;
            end
          end else begin
            rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
            // Repeats only count while the key reads pressed, so they stop
            // as soon as a released tick starts the release debounce.
            if (rep_q == REP_W'(1)) begin
              push  = 1'b1;
              rep_d = REP_W'(REPEAT_RATE);
            end else begin
              rep_d = rep_q - REP_W'(1);
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign push_code = {4'h0, row_q, col_d};
  assign key_held  = (state_q == HELD);

  // FSM state, captured key and registered row drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      db_q       <= '0;
      rel_q      <= '0;
      row_select <= 4'b1110;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      db_q       <= db_d;
      rel_q      <= rel_d;
      row_select <= ~(4'b0001 << row_d);
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign pop    = (count != '0) && kbus.key_ready;
  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign accept = push && (!full || pop);

  // Key-event FIFO; a full FIFO only drops when no pop frees a slot this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push && full && !pop;
      if (accept) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept && !pop)      count <= count + CNT_W'(1);
      else if (!accept && pop) count <= count - CNT_W'(1);
    end
  end

  assign kbus.key_code  = mem[rd_ptr];
  assign kbus.key_valid = (count != '0);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl (CLK_DIV=4, DEBOUNCE_TICKS=2,
// FIFO_DEPTH=4, REPEAT_DELAY=8, REPEAT_RATE=4). A keypad model drives col_in
// from the pressed key and the live row drive; expected codes go into a queue
// and a monitor pops them as beats are accepted.
module tb_keypad_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_select;
  logic       key_held;
  logic       overflow;

  logic       key_down  = 1'b0;
  logic [1:0] key_row   = 2'd0;
  logic [1:0] key_col   = 2'd0;
  logic       force_en  = 1'b0;
  logic [3:0] col_force = 4'hF;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  int ovf_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_code;

  keypad_scan_if kbus();

  keypad_scan_ctrl #(
    .CLK_DIV(4), .DEBOUNCE_TICKS(2), .FIFO_DEPTH(4),
    .REPEAT_DELAY(8), .REPEAT_RATE(4)
  ) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_select(row_select),
    .key_held(key_held), .overflow(overflow), .kbus(kbus.master)
  );

  always #5 clk = ~clk;

  assign col_in = force_en ? col_force :
                  (key_down && row_select == ~(4'b0001 << key_row)) ? ~(4'b0001 << key_col) : 4'hF;

  // Scoreboard: every accepted beat must match the oldest expected code.
  always @(negedge clk) begin
    #1;
    if (!rst && kbus.key_valid && kbus.key_ready) begin
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat got=%h expected=none", kbus.key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (kbus.key_code !== exp_code) begin
          failures++;
          $display("FAIL beat_code got=%h expected=%h", kbus.key_code, exp_code);
        end
      end
    end
    if (!rst && overflow === 1'b1) ovf_seen++;
  end

  task automatic wait_held(input logic val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (key_held === val) begin ok = 1'b1; break; end
    end
  endtask

  // Waits for the row drive to switch onto row r (just after a tick edge).
  task automatic wait_row(input logic [1:0] r, output bit ok);
    logic [3:0] target;
    logic [3:0] prev;
    target = ~(4'b0001 << r);
    prev   = row_select;
    ok     = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (row_select === target && prev !== target) begin ok = 1'b1; break; end
      prev = row_select;
    end
  endtask

  task automatic test_reset;
    logic [3:0] walk [4];
    walk[0] = 4'b1101; walk[1] = 4'b1011; walk[2] = 4'b0111; walk[3] = 4'b1110;
    rst = 1'b1;
    kbus.key_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (row_select !== 4'b1110) begin failures++; $display("FAIL reset_row got=%b expected=1110", row_select); end
    if (kbus.key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b expected=0", kbus.key_valid); end
    if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b expected=0", key_held); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
    if (kbus.key_code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h expected=00", kbus.key_code); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      checks++;
      if (row_select !== walk[i]) begin
        failures++;
        $display("FAIL row_walk%0d got=%b expected=%b", i, row_select, walk[i]);
      end
    end
  endtask

  task automatic test_press;
    bit ok;
    int b0;
    b0 = beats;
    exp_q.push_back(8'h09);
    key_row = 2'd2; key_col = 2'd1; key_down = 1'b1;
    wait_held(1'b1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL press_held got=timeout expected=1"); end
    repeat (8) @(negedge clk);
    key_down = 1'b0;
    wait_held(1'b0, ok);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL press_release got=timeout expected=0"); end
    if (row_select !== 4'b0111) begin failures++; $display("FAIL press_resume_row got=%b expected=0111", row_select); end
    if (beats - b0 != 1) begin failures++; $display("FAIL press_beats got=%0d expected=1", beats - b0); end
  endtask

  task automatic test_bounce;
    bit ok;
    int b0;
    b0 = beats;
    wait_row(2'd0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bounce_row_wait got=timeout expected=row0"); end
    force_en = 1'b1; col_force = 4'b1110;
    repeat (4) @(negedge clk);
    col_force = 4'hF;
    repeat (4) @(negedge clk);
    checks += 3;
    if (row_select !== 4'b1101) begin failures++; $display("FAIL bounce_row got=%b expected=1101", row_select); end
    if (key_held !== 1'b0) begin failures++; $display("FAIL bounce_held got=%b expected=0", key_held); end
    repeat (8) @(negedge clk);
    if (beats != b0) begin failures++; $display("FAIL bounce_beats got=%0d expected=0", beats - b0); end
    force_en = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    int b0;
    int o0;
    logic [1:0] rows [5];
    logic [1:0] cols [5];
    rows[0] = 2'd1; cols[0] = 2'd2;
    rows[1] = 2'd2; cols[1] = 2'd3;
    rows[2] = 2'd3; cols[2] = 2'd1;
    rows[3] = 2'd0; cols[3] = 2'd0;
    rows[4] = 2'd2; cols[4] = 2'd0;
    b0 = beats;
    o0 = ovf_seen;
    kbus.key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({4'h0, rows[i], cols[i]});
      key_row = rows[i]; key_col = cols[i]; key_down = 1'b1;
      wait_held(1'b1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_press%0d got=timeout expected=held", i); end
      repeat (4) @(negedge clk);
      key_down = 1'b0;
      wait_held(1'b0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_release%0d got=timeout expected=released", i); end
    end
    checks += 3;
    if (ovf_seen - o0 != 1) begin failures++; $display("FAIL bp_overflow got=%0d expected=1", ovf_seen - o0); end
    if (kbus.key_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b expected=1", kbus.key_valid); end
    if (kbus.key_code !== 8'h06) begin failures++; $display("FAIL bp_head got=%h expected=06", kbus.key_code); end
    kbus.key_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (kbus.key_valid === 1'b0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL bp_drain got=timeout expected=valid_low"); end
    if (beats - b0 != 4) begin failures++; $display("FAIL bp_beats got=%0d expected=4", beats - b0); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL bp_queue got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_rst_mid;
    bit ok;
    int b0;
    b0 = beats;
    kbus.key_ready = 1'b0;
    key_row = 2'd0; key_col = 2'd2; key_down = 1'b1;
    wait_held(1'b1, ok);
    key_down = 1'b0;
    wait_held(1'b0, ok);
    checks++;
    if (kbus.key_valid !== 1'b1) begin failures++; $display("FAIL rst_prefill_valid got=%b expected=1", kbus.key_valid); end
    wait_row(2'd1, ok);
    key_row = 2'd1; key_col = 2'd1; key_down = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    key_down = 1'b0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (row_select !== 4'b1110) begin failures++; $display("FAIL rst_mid_row got=%b expected=1110", row_select); end
    if (kbus.key_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b expected=0", kbus.key_valid); end
    if (key_held !== 1'b0) begin failures++; $display("FAIL rst_mid_held got=%b expected=0", key_held); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_overflow got=%b expected=0", overflow); end
    if (kbus.key_code !== 8'h00) begin failures++; $display("FAIL rst_mid_code got=%h expected=00", kbus.key_code); end
    rst = 1'b0;
    kbus.key_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (row_select !== 4'b1101) begin failures++; $display("FAIL rst_restart_row got=%b expected=1101", row_select); end
    repeat (40) @(negedge clk);
    checks++;
    if (beats != b0) begin failures++; $display("FAIL rst_mid_beats got=%0d expected=0", beats - b0); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat;
    bit ok;
    int b0;
    b0 = beats;
    kbus.key_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h0E);
    key_row = 2'd3; key_col = 2'd2; key_down = 1'b1;
    wait_held(1'b1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL repeat_held got=timeout expected=1"); end
    repeat (20 * 4 + 2) @(negedge clk);
    key_down = 1'b0;
    wait_held(1'b0, ok);
    repeat (4) @(negedge clk);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL repeat_release got=timeout expected=0"); end
    if (beats - b0 != 5) begin failures++; $display("FAIL repeat_beats got=%0d expected=5", beats - b0); end
  endtask
`endif

  initial begin
    kbus.key_ready = 1'b1;
    test_reset();
    test_press();
    test_bounce();
    test_backpressure();
    test_rst_mid();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    repeat (8) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL final_queue got=%0d expected=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
